// File: rtl/cube_layer_driver.sv
// -----------------------------------------------------------------------------
// cube_layer_driver
//
// Display stage for an 8x8x8 LED cube. It takes the cell state of each
// generation and scans it onto the cube one z-layer at a time:
//   BLANK  one cycle. Swaps in a new frame when layer 0 is about to be drawn.
//          Loads the 64 column bits of the current layer.
//   SHIFT  clocks those 64 bits MSB first into an external SIPO chain.
//   LATCH  pulses the chain's storage latch.
//   DWELL  enables the layer's driver for a fixed time, then moves on.
// The frame is double-buffered. A new generation that arrives mid-frame waits
// in a pending buffer until the next frame boundary, so a scan never tears.
//
// Ports
//   Clk          system clock, rising edge
//   Rst_n        asynchronous active-low reset
//   Cells[511:0] cell state, bit index = z*64 + y*8 + x
//   Cells_valid  one-cycle strobe marking a new generation on Cells
//   Ser_Data     serial data to the column chain
//   Ser_Clk      shift clock to the chain (the chain samples on its rising edge)
//   Latch        storage latch pulse to the chain
//   Layer_En     one-hot layer enable, non-zero only during DWELL
//   Layer_Idx    layer currently being loaded or displayed
//   Frame_Done   one-cycle pulse at the end of the layer-7 dwell
// -----------------------------------------------------------------------------
module cube_layer_driver #(
  parameter int SCLK_DIV     = 2,     // Clk cycles per Ser_Clk half-period, >= 1
  parameter int DWELL_CYCLES = 1000,  // Clk cycles a layer stays lit, >= 1
  parameter int LATCH_CYCLES = 2      // Clk cycles Latch stays high, >= 1
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [511:0] Cells,
  input  logic         Cells_valid,
  output logic         Ser_Data,
  output logic         Ser_Clk,
  output logic         Latch,
  output logic [7:0]   Layer_En,
  output logic [2:0]   Layer_Idx,
  output logic         Frame_Done
);

  // One counter times the Ser_Clk half-periods, the latch pulse and the dwell.
  // It never runs past the longest of the three intervals.
  localparam int MAX_A   = (SCLK_DIV > LATCH_CYCLES) ? SCLK_DIV : LATCH_CYCLES;
  localparam int MAX_CNT = (MAX_A > DWELL_CYCLES) ? MAX_A : DWELL_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_SHIFT,
    ST_LATCH,
    ST_DWELL
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         layer_q, layer_d;
  logic [5:0]         bit_q, bit_d;      // bits still to send after the current one
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;  // 0: Ser_Clk low half, 1: high half
  logic [63:0]        sr_q, sr_d;        // shift register for the current layer
  logic               ser_q, ser_d;
  logic [511:0]       disp_q, disp_d;    // frame being scanned
  logic [511:0]       pbuf_q, pbuf_d;    // newest generation not yet shown
  logic               pend_q, pend_d;

  logic               swap_slot;         // the only cycle where a new frame may enter

  assign swap_slot = (state_q == ST_BLANK) && (layer_q == 3'd0);

  // NOTE: every signal driven here gets its default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    sr_d    = sr_q;
    ser_d   = ser_q;
    disp_d  = disp_q;
    pbuf_d  = pbuf_q;
    pend_d  = pend_q;

    // A strobe outside the swap slot only parks the data. The frame in
    // progress keeps scanning the old buffer. The last strobe wins.
    if (Cells_valid && !swap_slot) begin
      pbuf_d = Cells;
      pend_d = 1'b1;
    end

    case (state_q)
      ST_BLANK: begin
        if (layer_q == 3'd0) begin
          // A strobe on this very cycle has priority over the parked frame,
          // so the frame about to start already shows the new data.
          if (Cells_valid) begin
            disp_d = Cells;
          end else if (pend_q) begin
            disp_d = pbuf_q;
          end
          pend_d = 1'b0;
        end
        // Slice from disp_d so a frame swapped in on this cycle is used at once.
        sr_d    = disp_d[{layer_q, 6'd0} +: 64];
        ser_d   = sr_d[63];
        bit_d   = 6'd63;
        cnt_d   = '0;
        phase_d = 1'b0;
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // Ser_Clk falls here. The next bit appears on the same cycle,
            // which keeps it stable for the whole following rising edge.
            phase_d = 1'b0;
            if (bit_q == 6'd0) begin
              state_d = ST_LATCH;   // Ser_Data keeps bit 0 through LATCH
            end else begin
              bit_d = bit_q - 6'd1;
              sr_d  = {sr_q[62:0], 1'b0};
              ser_d = sr_q[62];
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          cnt_d   = '0;
          state_d = ST_DWELL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DWELL: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d   = '0;
          layer_d = layer_q + 3'd1;   // wraps 7 -> 0
          state_d = ST_BLANK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_BLANK;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then updates from the values before the edge, whatever the statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_BLANK;
      layer_q <= 3'd0;
      bit_q   <= 6'd63;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      sr_q    <= '0;
      ser_q   <= 1'b0;
      // NOTE: both frame buffers are reset on purpose. The cube must come up
      // dark, not showing whatever the flops powered up with.
      disp_q  <= '0;
      pbuf_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      sr_q    <= sr_d;
      ser_q   <= ser_d;
      disp_q  <= disp_d;
      pbuf_q  <= pbuf_d;
      pend_q  <= pend_d;
    end
  end

  // Outputs decode straight from reset-cleared registers. Pulling Rst_n low
  // therefore blanks the cube and the chain controls without waiting for Clk.
  assign Ser_Data   = ser_q;
  assign Ser_Clk    = (state_q == ST_SHIFT) && phase_q;
  assign Latch      = (state_q == ST_LATCH);
  assign Layer_En   = (state_q == ST_DWELL) ? (8'd1 << layer_q) : 8'd0;
  assign Layer_Idx  = layer_q;
  assign Frame_Done = (state_q == ST_DWELL) && (cnt_q == DWELL_LAST) && (layer_q == 3'd7);

endmodule

// File: tb/tb_cube_layer_driver.sv
// -----------------------------------------------------------------------------
// tb_cube_layer_driver
//
// Self-checking bench for cube_layer_driver with SCLK_DIV=1, DWELL_CYCLES=4
// and LATCH_CYCLES=2. That gives a 135-cycle layer and a 1080-cycle frame.
// The reference model works out every output from the cycle position within
// the frame, plus a two-buffer model of frame capture and swap.
// -----------------------------------------------------------------------------
module tb_cube_layer_driver;

  localparam int SCLK_DIV     = 1;
  localparam int DWELL_CYCLES = 4;
  localparam int LATCH_CYCLES = 2;
  localparam int SHIFT_LEN    = 128 * SCLK_DIV;
  localparam int LAYER_P      = 1 + SHIFT_LEN + LATCH_CYCLES + DWELL_CYCLES;
  localparam int FRAME_P      = 8 * LAYER_P;

  logic         Clk;
  logic         Rst_n;
  logic [511:0] Cells;
  logic         Cells_valid;
  logic         Ser_Data;
  logic         Ser_Clk;
  logic         Latch;
  logic [7:0]   Layer_En;
  logic [2:0]   Layer_Idx;
  logic         Frame_Done;

  cube_layer_driver #(
    .SCLK_DIV     (SCLK_DIV),
    .DWELL_CYCLES (DWELL_CYCLES),
    .LATCH_CYCLES (LATCH_CYCLES)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Cells       (Cells),
    .Cells_valid (Cells_valid),
    .Ser_Data    (Ser_Data),
    .Ser_Clk     (Ser_Clk),
    .Latch       (Latch),
    .Layer_En    (Layer_En),
    .Layer_Idx   (Layer_Idx),
    .Frame_Done  (Frame_Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int vectors = 0;
  int fails   = 0;

  // Reference model state.
  logic [511:0] m_disp;   // frame being shown
  logic [511:0] m_pbuf;   // newest parked generation
  bit           m_pend;
  bit           m_ser;    // last bit presented on Ser_Data
  int           t;        // cycles since reset release

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0d got=%h expected=%h", tag, t, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Compare every output with the model for cycle t.
  task automatic check_cycle();
    int   layer, pos, bidx;
    logic [7:0] e_en;
    bit   e_latch, e_sclk, e_fd;
    layer = (t / LAYER_P) % 8;
    pos   = t % LAYER_P;
    e_en    = (pos >= LAYER_P - DWELL_CYCLES) ? 8'(1 << layer) : 8'h00;
    e_latch = (pos > SHIFT_LEN) && (pos <= SHIFT_LEN + LATCH_CYCLES);
    e_sclk  = (pos >= 1) && (pos <= SHIFT_LEN) && (((pos - 1) / SCLK_DIV) % 2 == 1);
    e_fd    = (layer == 7) && (pos == LAYER_P - 1);
    if (pos >= 1 && pos <= SHIFT_LEN) begin
      bidx  = layer * 64 + 63 - (pos - 1) / (2 * SCLK_DIV);
      m_ser = m_disp[bidx];
    end
    check("layer_en",   64'(Layer_En),   64'(e_en));
    check("latch",      64'(Latch),      64'(e_latch));
    check("ser_clk",    64'(Ser_Clk),    64'(e_sclk));
    check("ser_data",   64'(Ser_Data),   64'(m_ser));
    check("layer_idx",  64'(Layer_Idx),  64'(layer));
    check("frame_done", 64'(Frame_Done), 64'(e_fd));
  endtask

  // One clock cycle. Check the outputs, drive the inputs, update the model,
  // then move on to the next falling edge.
  task automatic step(input bit v, input logic [511:0] c);
    check_cycle();
    Cells_valid = v;
    Cells       = c;
    if ((t % FRAME_P) == 0) begin
      if (v)           m_disp = c;
      else if (m_pend) m_disp = m_pbuf;
      m_pend = 1'b0;
    end else if (v) begin
      m_pbuf = c;
      m_pend = 1'b1;
    end
    @(negedge Clk);
    t++;
  endtask

  // Idle up to cycle target. Junk is driven on Cells to show it is ignored.
  task automatic run_to(input int target);
    while (t < target) step(1'b0, rand512());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},    64'(Layer_En),   64'h0);
    check({tag, "_sclk"},  64'(Ser_Clk),    64'h0);
    check({tag, "_latch"}, 64'(Latch),      64'h0);
    check({tag, "_sdata"}, 64'(Ser_Data),   64'h0);
    check({tag, "_idx"},   64'(Layer_Idx),  64'h0);
    check({tag, "_fd"},    64'(Frame_Done), 64'h0);
  endtask

  task automatic model_reset();
    m_disp = '0;
    m_pbuf = '0;
    m_pend = 1'b0;
    m_ser  = 1'b0;
    t      = 0;
  endtask

  initial begin
    logic [511:0] pat;
    Rst_n       = 1'b0;
    Cells_valid = 1'b0;
    Cells       = '0;
    model_reset();
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Rst_n = 1'b1;

    // Frame 0 stays dark. Mid-frame, park a layer-0 pattern with both end bits set.
    run_to(2 * LAYER_P + 50);
    pat = '0;
    pat[63:0] = 64'h8000_0000_0000_0001;
    step(1'b1, pat);

    // Frame 1 shows the pattern. In the layer-3 dwell, park all ones.
    // Layers 4-7 of frame 1 must stay dark.
    run_to(FRAME_P + 3 * LAYER_P + (LAYER_P - DWELL_CYCLES));
    check("l3_dwell_en", 64'(Layer_En), 64'h08);
    step(1'b1, {512{1'b1}});

    // Frame 2 is all ones. Two strobes land in it, and only the last may show.
    run_to(2 * FRAME_P + 300);
    step(1'b1, '0);
    run_to(2 * FRAME_P + 700);
    step(1'b1, {8{64'hAAAA_AAAA_AAAA_AAAA}});

    // Frame 3 shows the checkerboard. Sparse random strobes arrive in it.
    while (t < 4 * FRAME_P) step(($urandom_range(99) == 0), rand512());

    // A strobe on the exact layer-0 blank cycle shows in that same frame.
    step(1'b1, rand512());

    // Random strobes during frame 4, up to the high half of a layer-5 Ser_Clk.
    while (t < 4 * FRAME_P + 5 * LAYER_P + 2) step(($urandom_range(199) == 0), rand512());
    check_cycle();
    check("pre_rst_sclk", 64'(Ser_Clk), 64'h1);

    // Reset in the middle of a clock phase: outputs must drop with no edge.
    #2 Rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    Cells_valid = 1'b0;
    repeat (2) @(negedge Clk);
    check_all_zero("held_rst");
    model_reset();
    Rst_n = 1'b1;

    // After the reset the cube is blank again. Then one random frame shows.
    run_to(FRAME_P + 10);
    step(1'b1, rand512());
    run_to(2 * FRAME_P + 2 * LAYER_P);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  // Backstop so a broken DUT or bench can never hang the run.
  initial begin
    #2_000_000;
    $display("FAIL timeout t=%0d got=running required=finished", t);
    $fatal(1, "timeout");
  end

endmodule
